pulse_meter: RTL and testbench
==============================

Name: pulse_meter

Overview:
- Sits directly downstream of the max-duration pulse generator.
- Measures the width, in clock cycles, of each high pulse on `pulse`.
- Emits each width as a byte to a downstream consumer over the dav/rfd 4-phase handshake.
- Uses a one-entry holding register, so measurement and delivery overlap.

Parameters:
- W, 8, width of the counter, the holding register and `data`. Widths saturate at 2^W-1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- pulse  in  1  pulse to measure (the upstream stage's `out`); synchronous to clock.
- rfd  in  1  ready-for-data from the consumer; active high.
- dav  out  1  data-available to the consumer; active high.
- data  out  W  measured width; valid and stable while dav=1.
- ovr  out  1  sticky overrun flag; present only with the optional feature.

Behaviour:
- Reset (reset_=0, asynchronous):
  - MST=IDLE, HST=H0, COUNT=0, HOLD=0, FULL=0.
  - dav=0, data=0, ovr=0.
  - Reset mid-pulse or mid-handshake discards everything; no partial result is ever emitted.
- Measure FSM MST, sampled on every rising edge:
  - IDLE, pulse=0: stay.
  - IDLE, pulse=1: COUNT<=1, go to MEAS.
  - MEAS, pulse=1: COUNT<=COUNT+1, saturating at 2^W-1 (no wrap to 0).
  - MEAS, pulse=0: pulse complete, result=COUNT, go to IDLE.
- Width definition: width = number of rising edges at which pulse is sampled 1. Minimum 1.
- Pulse already high when reset releases: measured from the first sampled 1.
- Holding register:
  - On completion with FULL=0, or FULL being cleared this same edge: HOLD<=result, FULL<=1.
  - Otherwise the result is dropped and ovr is set (if compiled in).
- Output FSM HST:
  - H0 (dav=0): if FULL & rfd, go to H1.
  - H1 (dav=1): if ~rfd, FULL<=0 and go to H2.
  - H2 (dav=0): if rfd, go to H0.
- data = HOLD at all times. HOLD is never written while dav=1 (FULL=1 throughout H1), so data is stable for the whole dav=1 phase.
- Latency: pulse falls at edge k, so FULL=1 after edge k. dav rises after edge k+1 if rfd=1.
- Back-to-back pulses (one low cycle between them) are counted independently. The second result is accepted only if FULL has cleared by its completion edge.
- Simultaneous completion and FULL-clear: the new value loads, FULL stays 1, no overrun.
- rfd held 0 forever: dav stays 1 and data stays frozen; later completions overrun.

Optional Feature:
- Macro: PULSE_METER_OVERRUN_EN.
- Defined:
  - Port `ovr` exists.
  - ovr goes to 1 on the edge where a completed result is dropped, and stays 1 until reset.
- Undefined:
  - Port `ovr` and its register are absent.
  - Dropped results are silently discarded; all other behaviour is identical.

Decomposition:
- Shared package: MST encodings (IDLE, MEAS) and HST encodings (H0, H1, H2) as localparams, plus the default W.
- One natural sub-module: sat_inc (W-bit saturating incrementer, combinational), used for COUNT.
- Both FSMs stay in pulse_meter.

Test Plan:
- Reset mid-pulse: pulse high 3 cycles, reset_ pulsed low, pulse low -> dav stays 0, data=0, ovr=0; the next 2-cycle pulse yields data=2.
- Single pulse, rfd=1: pulse high 5 cycles -> dav=1 two edges after the fall, data=5; rfd 0 then 1 -> dav 1 then 0, FSM returns to H0.
- Saturation: W=8, pulse high 300 cycles -> data=255.
- Back-to-back with a slow consumer: pulses of 4, 7 and 2 cycles, one low cycle apart, rfd held 0 until after the third -> data=4 delivered; 7 fills HOLD after 4 clears only if timed so, otherwise 2 is dropped and ovr=1 (macro defined). Check exact drop order.
- Simultaneous: a 3-cycle pulse completes on the same edge HST leaves H1 -> next delivery data=3, ovr=0.
- Pulse high at reset release, 1 cycle wide -> data=1.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse_meter block.
//   - DefaultW: default counter / holding register / data width.
//   - Measure FSM (MST) and output handshake FSM (HST) encodings.
// The optional overrun flag is enabled by defining PULSE_METER_OVERRUN_EN.
package pulse_meter_pkg;

  localparam int unsigned DefaultW = 8;

  // Measure FSM encodings
  localparam logic MstIdleEnc = 1'b0;
  localparam logic MstMeasEnc = 1'b1;

  // Output handshake FSM encodings
  localparam logic [1:0] HstH0Enc = 2'd0;
  localparam logic [1:0] HstH1Enc = 2'd1;
  localparam logic [1:0] HstH2Enc = 2'd2;

  typedef enum logic {
    MstIdle = MstIdleEnc,
    MstMeas = MstMeasEnc
  } mst_e;

  typedef enum logic [1:0] {
    HstH0 = HstH0Enc,
    HstH1 = HstH1Enc,
    HstH2 = HstH2Enc
  } hst_e;

endpackage

// File: rtl/pulse_meter_sat_inc.sv
// W-bit saturating incrementer (combinational).
// Ports:
//   value_i  current value
//   value_o  value_i + 1, held at all-ones instead of wrapping to zero
module sat_inc
  import pulse_meter_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic [W-1:0] value_i,
  output logic [W-1:0] value_o
);

  assign value_o = (&value_i) ? value_i : value_i + W'(1);

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures the width (in clock cycles) of each high pulse on `pulse` and
// delivers it as a W-bit value over a dav/rfd 4-phase handshake. A one-entry holding
// register lets the next measurement proceed while the previous one is being delivered.
// Ports:
//   clock   system clock, rising edge
//   reset_  asynchronous active-low reset
//   pulse   pulse to measure, synchronous to clock
//   rfd     ready-for-data from the consumer
//   dav     data-available to the consumer
//   data    measured width (saturates at 2^W-1), stable while dav=1
//   ovr     sticky overrun flag, only when PULSE_METER_OVERRUN_EN is defined
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         pulse,
  input  logic         rfd,
  output logic         dav,
  output logic [W-1:0] data
`ifdef PULSE_METER_OVERRUN_EN
  ,
  output logic         ovr
`endif
);

  mst_e         mst_q;
  hst_e         hst_q;
  logic [W-1:0] count_q;
  logic [W-1:0] count_inc;
  logic [W-1:0] hold_q;
  logic         full_q;
  logic         dav_q;
  logic         done;
  logic         full_clr;
  logic         load;

  sat_inc #(
    .W(W)
  ) u_sat_inc (
    .value_i(count_q),
    .value_o(count_inc)
  );

  // Pulse completes on the first edge that samples it low while measuring.
  assign done     = (mst_q == MstMeas) && !pulse;
  // The consumer has taken the data: HOLD is free from this edge on.
  assign full_clr = (hst_q == HstH1) && !rfd;
  // A completion may reuse HOLD on the very edge it is released.
  assign load     = done && (!full_q || full_clr);

`ifdef PULSE_METER_OVERRUN_EN
  logic ovr_q;
  assign ovr = ovr_q;
`endif

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      mst_q   <= MstIdle;
      hst_q   <= HstH0;
      count_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      dav_q   <= 1'b0;
`ifdef PULSE_METER_OVERRUN_EN
      ovr_q   <= 1'b0;
`endif
    end else begin
      // Measure FSM
      unique case (mst_q)
        MstIdle: begin
          if (pulse) begin
            count_q <= W'(1);
            mst_q   <= MstMeas;
          end
        end
        MstMeas: begin
          if (pulse) begin
            count_q <= count_inc;
          end else begin
            mst_q <= MstIdle;
          end
        end
      endcase

      // Holding register
      if (load) begin
        hold_q <= count_q;
        full_q <= 1'b1;
      end else if (full_clr) begin
        full_q <= 1'b0;
      end

`ifdef PULSE_METER_OVERRUN_EN
      if (done && !load) begin
        ovr_q <= 1'b1;
      end
`endif

      // Output handshake FSM
      unique case (hst_q)
        HstH0: begin
          if (full_q && rfd) begin
            hst_q <= HstH1;
            dav_q <= 1'b1;
          end
        end
        HstH1: begin
          if (!rfd) begin
            hst_q <= HstH2;
            dav_q <= 1'b0;
          end
        end
        HstH2: begin
          if (rfd) begin
            hst_q <= HstH0;
          end
        end
        default: begin
          hst_q <= HstH0;
          dav_q <= 1'b0;
        end
      endcase
    end
  end

  assign dav  = dav_q;
  // HOLD only changes while dav=0, so data is stable for the whole dav=1 phase.
  assign data = hold_q;

endmodule

// File: tb/tb_pulse_meter.sv
module tb_pulse_meter;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset_;
  logic         pulse;
  logic         rfd;
  logic         dav;
  logic [W-1:0] data;
`ifdef PULSE_METER_OVERRUN_EN
  logic         ovr;
`endif

  int total = 0;
  int bad   = 0;

  int exp_q[$];
  bit auto_ack = 1'b1;
  bit dav_prev = 1'b0;
  int held     = 0;

  pulse_meter #(
    .W(W)
  ) dut (
    .clock (clock),
    .reset_(reset_),
    .pulse (pulse),
    .rfd   (rfd),
    .dav   (dav),
    .data  (data)
`ifdef PULSE_METER_OVERRUN_EN
    ,
    .ovr   (ovr)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each dav rise and checks data stays frozen while dav=1.
  always @(negedge clock) begin
    if (!reset_) begin
      dav_prev = 1'b0;
    end else begin
      if (dav && !dav_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", int'(data), -1);
        end else begin
          check("delivery", int'(data), exp_q.pop_front());
        end
        held = int'(data);
      end else if (dav && dav_prev) begin
        check("data_stable", int'(data), held);
      end
      dav_prev = dav;
    end
  end

  // Well-behaved consumer: drop rfd once dav is seen, raise it once dav is gone.
  always @(negedge clock) begin
    if (auto_ack) rfd = dav ? 1'b0 : 1'b1;
  end

  // Called at a negedge; pulse is sampled high on exactly n rising edges.
  task automatic do_pulse(input int n);
    pulse = 1'b1;
    repeat (n) @(negedge clock);
    pulse = 1'b0;
  endtask

  task automatic wait_dav(input logic val, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clock);
      if (dav == val) break;
    end
    if (i == budget) check("wait_dav_timeout", int'(dav), int'(val));
  endtask

  task automatic drain(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !dav) break;
    end
    if (i == 200) check({nm, "_drain_timeout"}, exp_q.size(), 0);
    repeat (4) @(negedge clock);
    check({nm, "_idle_dav"}, int'(dav), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_ = 1'b0;
    pulse  = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset_ = 1'b0;
    pulse  = 1'b0;
    rfd    = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_dav", int'(dav), 0);
    check("rst_data", int'(data), 0);
`ifdef PULSE_METER_OVERRUN_EN
    check("rst_ovr", int'(ovr), 0);
`endif
    reset_ = 1'b1;
    @(negedge clock);

    // Reset mid-pulse discards the partial measurement
    pulse = 1'b1;
    repeat (3) @(negedge clock);
    reset_ = 1'b0;
    pulse  = 1'b0;
    #1;
    check("midrst_dav", int'(dav), 0);
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    repeat (4) @(negedge clock);
    check("midrst_dav_after", int'(dav), 0);
    check("midrst_data_after", int'(data), 0);
`ifdef PULSE_METER_OVERRUN_EN
    check("midrst_ovr", int'(ovr), 0);
`endif
    exp_q.push_back(2);
    do_pulse(2);
    drain("midrst_next");

    // Single 5-cycle pulse with latency check
    exp_q.push_back(5);
    do_pulse(5);
    @(posedge clock);
    #1;
    check("lat_dav_edge_k", int'(dav), 0);
    @(posedge clock);
    #1;
    check("lat_dav_edge_k1", int'(dav), 1);
    check("lat_data", int'(data), 5);
    drain("single");

    // Saturation
    exp_q.push_back(255);
    do_pulse(300);
    drain("sat");

    // Slow consumer: 4 is held, 7 and 2 are dropped
    auto_ack = 1'b0;
    rfd      = 1'b0;
    @(negedge clock);
    do_pulse(4);
    @(negedge clock);
    do_pulse(7);
    @(negedge clock);
    do_pulse(2);
    repeat (3) @(negedge clock);
    check("slow_dav_held", int'(dav), 0);
    check("slow_data_held", int'(data), 4);
`ifdef PULSE_METER_OVERRUN_EN
    check("slow_ovr", int'(ovr), 1);
`endif
    exp_q.push_back(4);
    auto_ack = 1'b1;
    drain("slow");
`ifdef PULSE_METER_OVERRUN_EN
    check("slow_ovr_sticky", int'(ovr), 1);
`endif
    do_reset();
`ifdef PULSE_METER_OVERRUN_EN
    check("ovr_cleared", int'(ovr), 0);
`endif

    // Prompt consumer: 4, 7 and 2 each find HOLD free in time
    exp_q.push_back(4);
    exp_q.push_back(7);
    exp_q.push_back(2);
    do_pulse(4);
    @(negedge clock);
    do_pulse(7);
    @(negedge clock);
    do_pulse(2);
    drain("b2b");
`ifdef PULSE_METER_OVERRUN_EN
    check("b2b_ovr", int'(ovr), 0);
`endif

    // Completion on the same edge HST leaves H1
    auto_ack = 1'b0;
    rfd      = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(3);
    @(negedge clock);
    do_pulse(2);
    wait_dav(1'b1, 20);
    pulse = 1'b1;
    repeat (3) @(negedge clock);
    pulse = 1'b0;
    rfd   = 1'b0;
    @(posedge clock);
    #1;
    check("simul_dav", int'(dav), 0);
    check("simul_data", int'(data), 3);
    @(negedge clock);
    rfd      = 1'b1;
    auto_ack = 1'b1;
    drain("simul");
`ifdef PULSE_METER_OVERRUN_EN
    check("simul_ovr", int'(ovr), 0);
`endif

    // Pulse already high when reset releases
    @(negedge clock);
    reset_ = 1'b0;
    pulse  = 1'b1;
    @(negedge clock);
    exp_q.push_back(1);
    reset_ = 1'b1;
    @(negedge clock);
    pulse = 1'b0;
    drain("rst_release");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
